regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter (ALU vs LSU) for the single register-file write port; 1-cycle registered output, x0 writes dropped.
// Optional WB_BYPASS_EN adds combinational read forwarding across the write/read window.
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_stall,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [ADDR_W-1:0] lsu_rd,
   input  logic [DATA_W-1:0] lsu_data,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_rd,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [CNT_W-1:0]  conflict_cnt
`ifdef WB_BYPASS_EN
   ,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   input  logic [DATA_W-1:0] rf_rdata1,
   input  logic [DATA_W-1:0] rf_rdata2,
   output logic [DATA_W-1:0] fwd_data1,
   output logic [DATA_W-1:0] fwd_data2
`endif
);

   typedef enum logic {GNT_ALU = 1'b0, GNT_LSU = 1'b1} grant_e;

   grant_e              last_grant_q, last_grant_d;
   logic                rf_we_q, rf_we_d;
   logic [ADDR_W-1:0]   rf_rd_q, rf_rd_d;
   logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                grant_alu, grant_lsu, conflict;

   always_comb begin
      grant_alu    = !wb_stall && alu_valid && (!lsu_valid || last_grant_q == GNT_LSU);
      grant_lsu    = !wb_stall && lsu_valid && (!alu_valid || last_grant_q == GNT_ALU);
      conflict     = alu_valid && lsu_valid && !wb_stall;
      last_grant_d = last_grant_q;
      rf_we_d      = 1'b0;
      rf_rd_d      = rf_rd_q;
      rf_wdata_d   = rf_wdata_q;
      cnt_d        = cnt_q;
      // x0 targets are still accepted and registered, only the write enable is dropped
      if (grant_alu) begin
         last_grant_d = GNT_ALU;
         rf_we_d      = (alu_rd != '0);
         rf_rd_d      = alu_rd;
         rf_wdata_d   = alu_data;
      end else if (grant_lsu) begin
         last_grant_d = GNT_LSU;
         rf_we_d      = (lsu_rd != '0);
         rf_rd_d      = lsu_rd;
         rf_wdata_d   = lsu_data;
      end
      if (conflict && cnt_q != '1)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= GNT_LSU;
         rf_we_q      <= 1'b0;
         rf_rd_q      <= '0;
         rf_wdata_q   <= '0;
         cnt_q        <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         rf_we_q      <= rf_we_d;
         rf_rd_q      <= rf_rd_d;
         rf_wdata_q   <= rf_wdata_d;
         cnt_q        <= cnt_d;
      end
   end

   assign alu_ready    = grant_alu;
   assign lsu_ready    = grant_lsu;
   assign rf_we        = rf_we_q;
   assign rf_rd        = rf_rd_q;
   assign rf_wdata     = rf_wdata_q;
   assign conflict_cnt = cnt_q;

`ifdef WB_BYPASS_EN
   assign fwd_data1 = (rf_we_q && rf_rd_q == rs1 && rs1 != '0) ? rf_wdata_q : rf_rdata1;
   assign fwd_data2 = (rf_we_q && rf_rd_q == rs2 && rs2 != '0) ? rf_wdata_q : rf_rdata2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: scoreboard monitor plus directed scenario tasks.
// Latency: monitor predicts grant in cycle N and checks the registered write in cycle N+1.
// Backpressure: drives wb_stall and simultaneous valids to exercise ready withholding.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_stall, alu_valid, lsu_valid;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready, rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [15:0] conflict_cnt;
    logic        s_alu_ready, s_lsu_ready, s_rf_we;
    logic [4:0]  s_rf_rd;
    logic [31:0] s_rf_wdata;
    logic [3:0]  s_conflict_cnt;
`ifdef WB_BYPASS_EN
    logic [4:0]  rs1, rs2;
    logic [31:0] rf_rdata1, rf_rdata2, fwd_data1, fwd_data2;
    logic [31:0] s_fwd_data1, s_fwd_data2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .conflict_cnt(conflict_cnt)
`ifdef WB_BYPASS_EN
        , .rs1(rs1), .rs2(rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
    );

    // narrow-counter copy sharing all inputs, used to observe saturation quickly
    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall),
        .alu_valid(alu_valid), .alu_ready(s_alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(s_lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_we(s_rf_we), .rf_rd(s_rf_rd), .rf_wdata(s_rf_wdata), .conflict_cnt(s_conflict_cnt)
`ifdef WB_BYPASS_EN
        , .rs1(rs1), .rs2(rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_data1(s_fwd_data1), .fwd_data2(s_fwd_data2)
`endif
    );

    typedef struct packed {
        logic        xfer;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e_pop, e_new;
    logic        m_last;
    int unsigned m_cnt;
    logic        m_alu, m_lsu;
    logic [3:0]  s_exp;

    // scoreboard: expected write pushed when a grant is predicted, popped one cycle later
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            m_last = 1'b1;
            m_cnt  = 0;
        end else begin
            if (sb_q.size() > 0) begin
                e_pop = sb_q.pop_front();
                checks++;
                if (rf_we !== e_pop.we) begin
                    errors++;
                    $display("FAIL mon_we: got %0b want %0b at %0t", rf_we, e_pop.we, $time);
                end
                if (e_pop.xfer) begin
                    checks++;
                    if (rf_rd !== e_pop.rd || rf_wdata !== e_pop.data) begin
                        errors++;
                        $display("FAIL mon_wr: got rd=%0d data=%h want rd=%0d data=%h", rf_rd, rf_wdata, e_pop.rd, e_pop.data);
                    end
                end
            end
            checks++;
            if (conflict_cnt !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL mon_cnt: got %0d want %0d", conflict_cnt, m_cnt);
            end
            s_exp = (m_cnt > 15) ? 4'd15 : 4'(m_cnt);
            checks++;
            if (s_conflict_cnt !== s_exp) begin
                errors++;
                $display("FAIL mon_sat_cnt: got %0d want %0d", s_conflict_cnt, s_exp);
            end
            m_alu = !wb_stall && alu_valid && (!lsu_valid || m_last);
            m_lsu = !wb_stall && lsu_valid && (!alu_valid || !m_last);
            checks++;
            if (alu_ready !== m_alu || lsu_ready !== m_lsu) begin
                errors++;
                $display("FAIL mon_ready: got alu=%0b lsu=%0b want alu=%0b lsu=%0b", alu_ready, lsu_ready, m_alu, m_lsu);
            end
            e_new = '0;
            if (m_alu) begin
                e_new  = '{xfer: 1'b1, we: (alu_rd != 5'd0), rd: alu_rd, data: alu_data};
                m_last = 1'b0;
            end else if (m_lsu) begin
                e_new  = '{xfer: 1'b1, we: (lsu_rd != 5'd0), rd: lsu_rd, data: lsu_data};
                m_last = 1'b1;
            end
            sb_q.push_back(e_new);
            if (alu_valid && lsu_valid && !wb_stall && m_cnt < 65535)
                m_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wb_stall  = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
`ifdef WB_BYPASS_EN
        rs1 = 5'd0; rs2 = 5'd0; rf_rdata1 = 32'd0; rf_rdata2 = 32'd0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic single(input logic is_alu, input logic [4:0] rd, input logic [31:0] d);
        if (is_alu) begin alu_valid = 1'b1; alu_rd = rd; alu_data = d; end
        else begin lsu_valid = 1'b1; lsu_rd = rd; lsu_data = d; end
        smp();
        checks++;
        if ((is_alu ? alu_ready : lsu_ready) !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got 0 want 1 (alu=%0b rd=%0d)", is_alu, rd);
        end
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            smp();
            checks++;
            if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0 || conflict_cnt !== 16'd0) begin
                errors++;
                $display("FAIL reset_outs: got we=%0b rd=%0d data=%h cnt=%0d want all 0", rf_we, rf_rd, rf_wdata, conflict_cnt);
            end
            checks++;
            if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready: got alu=%0b lsu=%0b want 0 0", alu_ready, lsu_ready);
            end
            step();
        end
    endtask

    task automatic test_single_alu();
        single(1'b1, 5'd5, 32'hDEADBEEF);
        smp();
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL alu_write: got we=%0b rd=%0d data=%h want 1 5 deadbeef", rf_we, rf_rd, rf_wdata);
        end
        step();
        smp();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL alu_we_drop: got %0b want 0", rf_we);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] seq;
        seq = 4'b1010;
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            smp();
            checks++;
            if (alu_ready !== ~seq[i] || lsu_ready !== seq[i]) begin
                errors++;
                $display("FAIL rr_grant%0d: got alu=%0b lsu=%0b want alu=%0b lsu=%0b", i, alu_ready, lsu_ready, ~seq[i], seq[i]);
            end
            step();
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        smp();
        checks++;
        if (conflict_cnt !== 16'd4) begin
            errors++;
            $display("FAIL rr_cnt: got %0d want 4", conflict_cnt);
        end
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd2 || rf_wdata !== 32'h22) begin
            errors++;
            $display("FAIL rr_last_write: got we=%0b rd=%0d data=%h want 1 2 22", rf_we, rf_rd, rf_wdata);
        end
        step();
    endtask

    task automatic test_x0();
        single(1'b1, 5'd3, 32'h33);
        single(1'b0, 5'd0, 32'h55);
        alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h99;
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hAA;
        smp();
        checks++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'h55) begin
            errors++;
            $display("FAIL x0_write: got we=%0b rd=%0d data=%h want 0 0 55", rf_we, rf_rd, rf_wdata);
        end
        checks++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL x0_next_tie: got alu=%0b lsu=%0b want 1 0", alu_ready, lsu_ready);
        end
        step();
        alu_valid = 1'b0;
        smp();
        step();
        lsu_valid = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        single(1'b0, 5'd4, 32'h44);
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h88;
        wb_stall  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            smp();
            checks++;
            if (alu_ready !== 1'b0 || lsu_ready !== 1'b0 || conflict_cnt !== 16'd0) begin
                errors++;
                $display("FAIL stall_hold%0d: got alu=%0b lsu=%0b cnt=%0d want 0 0 0", i, alu_ready, lsu_ready, conflict_cnt);
            end
            if (i == 1) begin
                checks++;
                if (rf_we !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_we: got %0b want 0", rf_we);
                end
            end
            step();
        end
        wb_stall = 1'b0;
        smp();
        checks++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got alu=%0b lsu=%0b want 1 0", alu_ready, lsu_ready);
        end
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        smp();
        checks++;
        if (conflict_cnt !== 16'd1) begin
            errors++;
            $display("FAIL stall_cnt: got %0d want 1", conflict_cnt);
        end
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC0;
        lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_data = 32'hD0;
        for (int i = 0; i < 20; i++) begin
            step();
            alu_data = alu_data + 32'd1;
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        smp();
        checks++;
        if (s_conflict_cnt !== 4'hF || conflict_cnt !== 16'd20) begin
            errors++;
            $display("FAIL sat: got narrow=%0d wide=%0d want 15 20", s_conflict_cnt, conflict_cnt);
        end
        step();
    endtask

    task automatic test_back_to_back();
        alu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_rd = 5'(i + 11); alu_data = 32'h1010_1010 * (i + 1);
            smp();
            checks++;
            if (alu_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: got 0 want 1", i);
            end
            if (i > 0) begin
                checks++;
                if (rf_we !== 1'b1 || rf_rd !== 5'(i + 10) || rf_wdata !== 32'h1010_1010 * i) begin
                    errors++;
                    $display("FAIL b2b_write%0d: got we=%0b rd=%0d data=%h want 1 %0d %h", i, rf_we, rf_rd, rf_wdata, i + 10, 32'h1010_1010 * i);
                end
            end
            step();
        end
        alu_valid = 1'b0;
        smp();
        step();
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        single(1'b1, 5'd7, 32'h1234);
        rs1 = 5'd7; rf_rdata1 = 32'd0; rs2 = 5'd0; rf_rdata2 = 32'hCAFE;
        #1;
        checks++;
        if (fwd_data1 !== 32'h1234 || fwd_data2 !== 32'hCAFE) begin
            errors++;
            $display("FAIL bypass_fwd: got %h %h want 1234 cafe", fwd_data1, fwd_data2);
        end
        step();
        checks++;
        if (fwd_data1 !== 32'd0) begin
            errors++;
            $display("FAIL bypass_nowrite: got %h want 0", fwd_data1);
        end
        rs1 = 5'd0; rf_rdata2 = 32'd0;
    endtask
`endif

    task automatic test_reset_mid();
        alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'hABCD;
        smp();
        @(posedge clk);
        #1 alu_valid = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got we=%0b want 1", rf_we);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0) begin
            errors++;
            $display("FAIL midrst_clear: got we=%0b rd=%0d data=%h want 0 0 0", rf_we, rf_rd, rf_wdata);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        smp();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: got %0b want 0", rf_we);
        end
        step();
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        #2;
        test_reset();
        test_single_alu();
        test_round_robin();
        test_x0();
        test_stall();
        test_saturation();
        test_back_to_back();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1);
    end

endmodule
